// File: rtl/mem_stage_ldq_pkg.sv
// Shared encodings for mem_stage_ldq: load sizes, FSM states and stall levels,
// plus the misalignment helper used by the MEM_ALIGN_EXC_EN build.
package mem_stage_ldq_pkg;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
  localparam logic [1:0] LD_D = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // On a 32-bit datapath a dword request is a word access, so it aligns as one.
  function automatic logic ld_misaligned(input logic [1:0] size, input logic [2:0] addr,
                                         input logic wide);
    case (size)
      LD_H:    return addr[0];
      LD_W:    return |addr[1:0];
      LD_D:    return wide ? |addr[2:0] : |addr[1:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ldq_ld_extract.sv
// Load data lane select and sign/zero extension; low address bits below the
// access size are ignored so every access is force-aligned.
module mem_stage_ldq_ld_extract
  import mem_stage_ldq_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [LANE_W-1:0] lane,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] data
);

  logic [LANE_W-1:0] lane_al;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sbit;

  always_comb begin
    lane_al = lane;
    mask    = '1;
    case (size)
      LD_B: mask = DATA_W'(8'hFF);
      LD_H: begin
        lane_al[0] = 1'b0;
        mask       = DATA_W'(16'hFFFF);
      end
      LD_W: begin
        lane_al[1:0] = 2'b00;
        mask         = DATA_W'(32'hFFFF_FFFF);
      end
      default: lane_al = '0;
    endcase
    shifted = rdata >> {lane_al, 3'b000};
    case (size)
      LD_B:    sbit = shifted[7];
      LD_H:    sbit = shifted[15];
      LD_W:    sbit = shifted[31];
      default: sbit = 1'b0;
    endcase
    data = (shifted & mask) | ({DATA_W{sbit & ~uns}} & ~mask);
  end

endmodule

// File: rtl/mem_stage_ldq.sv
// MEM pipeline stage with variable-latency load handling (IDLE/WAIT/HOLD FSM).
// Optional MEM_ALIGN_EXC_EN adds misaligned-load exception outputs.
module mem_stage_ldq
  import mem_stage_ldq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [31:0]        in_pc,
  input  logic               in_ld,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_uns,
  input  logic               in_rf_we,
  input  logic [REG_AW-1:0]  in_rf_waddr,
  input  logic [DATA_W-1:0]  in_ex_result,
  input  logic               dmem_rvalid,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               stallreq,
  output logic [31:0]        wb_pc,
  output logic               wb_rf_we,
  output logic [REG_AW-1:0]  wb_rf_waddr,
  output logic [DATA_W-1:0]  wb_rf_wdata,
  output logic               fwd_valid,
  output logic               fwd_we,
  output logic [REG_AW-1:0]  fwd_waddr,
  output logic [DATA_W-1:0]  fwd_wdata,
`ifdef MEM_ALIGN_EXC_EN
  output logic               exc_adel,
  output logic [31:0]        exc_badvaddr,
`endif
  output logic [1:0]         dbg_state,
  output logic               dbg_discard
);

  localparam int LANE_W = $clog2(DATA_W / 8);

  logic [31:0]       pc_q, pc_d;
  logic              ld_q, ld_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [1:0]        state_q, state_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              adv, rvalid_eff, ld_exc, ld_active, ld_ready, kill_discard;
  logic [DATA_W-1:0] ext_data, ld_data;
  logic              unused_stall;

  assign adv          = (stall[STAGE+1] == NO_STOP);
  assign rvalid_eff   = dmem_rvalid && !discard_q;
  assign unused_stall = ^stall;
  // A killed WAIT leaves a response in flight unless it lands on this very edge.
  assign kill_discard = (state_q == ST_WAIT) && (discard_q || !dmem_rvalid);

`ifdef MEM_ALIGN_EXC_EN
  assign ld_exc       = ld_q && ld_misaligned(size_q, res_q[2:0], DATA_W == 64);
  assign exc_adel     = ld_exc;
  assign exc_badvaddr = ld_exc ? res_q[31:0] : 32'd0;
`else
  assign ld_exc       = 1'b0;
`endif
  assign ld_active = ld_q && !ld_exc;

  always_comb begin
    pc_d    = pc_q;
    ld_d    = ld_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    res_d   = res_q;
    if (flush || (stall[STAGE] == STOP && adv)) begin
      pc_d    = '0;
      ld_d    = 1'b0;
      size_d  = '0;
      uns_d   = 1'b0;
      we_d    = 1'b0;
      waddr_d = '0;
      res_d   = '0;
    end else if (stall[STAGE] == NO_STOP) begin
      pc_d    = in_pc;
      ld_d    = in_ld;
      size_d  = in_ld_size;
      uns_d   = in_ld_uns;
      we_d    = in_rf_we;
      waddr_d = in_rf_waddr;
      res_d   = in_ex_result;
    end
  end

  mem_stage_ldq_ld_extract #(.DATA_W(DATA_W)) u_ld_extract (
    .rdata (dmem_rdata),
    .lane  (res_q[LANE_W-1:0]),
    .size  (size_q),
    .uns   (uns_q),
    .data  (ext_data)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    discard_d = discard_q;
    stallreq  = 1'b0;
    ld_ready  = 1'b1;
    ld_data   = ext_data;
    if (discard_q && dmem_rvalid) discard_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_active) begin
          if (rvalid_eff) begin
            if (!adv) begin
              state_d = ST_HOLD;
              hold_d  = ext_data;
            end
          end else begin
            stallreq = 1'b1;
            ld_ready = 1'b0;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (rvalid_eff) begin
          if (adv) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            hold_d  = ext_data;
          end
        end else begin
          stallreq = 1'b1;
          ld_ready = 1'b0;
        end
      end
      ST_HOLD: begin
        ld_data = hold_q;
        if (adv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      if (state_q == ST_WAIT) discard_d = kill_discard;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= '0;
      ld_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      res_q     <= '0;
      state_q   <= ST_IDLE;
      discard_q <= kill_discard;
      hold_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      ld_q      <= ld_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      res_q     <= res_d;
      state_q   <= state_d;
      discard_q <= discard_d;
      hold_q    <= hold_d;
    end
  end

  assign wb_pc       = pc_q;
  assign wb_rf_we    = we_q && !ld_exc;
  assign wb_rf_waddr = waddr_q;
  assign wb_rf_wdata = ld_active ? ld_data : res_q;
  assign fwd_we      = wb_rf_we;
  assign fwd_waddr   = wb_rf_waddr;
  assign fwd_wdata   = wb_rf_wdata;
  // Nothing to forward without a write, so fwd_valid also follows fwd_we.
  assign fwd_valid   = wb_rf_we && ld_ready;
  assign dbg_state   = state_q;
  assign dbg_discard = discard_q;

endmodule

// File: tb/tb_mem_stage_ldq.sv
// Directed bench for mem_stage_ldq: 32-bit instance for pipeline/FSM behaviour,
// 64-bit instance for wide extraction.
module tb_mem_stage_ldq;
  import mem_stage_ldq_pkg::*;

  localparam logic [5:0] SB_NONE   = 6'b000000;
  localparam logic [5:0] SB_MEMREQ = 6'b011111;
  localparam logic [5:0] SB_BUBBLE = 6'b001111;

  logic        clk, rst, flush;
  logic [5:0]  stall;
  logic [31:0] in_pc, in_ex_result, dmem_rdata;
  logic        in_ld, in_ld_uns, in_rf_we, dmem_rvalid;
  logic [1:0]  in_ld_size;
  logic [4:0]  in_rf_waddr;
  logic        stallreq, wb_rf_we, fwd_valid, fwd_we, dbg_discard;
  logic [31:0] wb_pc, wb_rf_wdata, fwd_wdata;
  logic [4:0]  wb_rf_waddr, fwd_waddr;
  logic [1:0]  dbg_state;

  logic [5:0]  stall64;
  logic        flush64, ld64, uns64, we64, rvalid64;
  logic [1:0]  size64;
  logic [63:0] ex64, rdata64, wdata64_o, fwd_wdata64;
  logic        stallreq64, we64_o, fwd_valid64, fwd_we64, discard64;
  logic [31:0] pc64_o;
  logic [4:0]  waddr64_o, fwd_waddr64;
  logic [1:0]  state64;
`ifdef MEM_ALIGN_EXC_EN
  logic        exc_adel, exc_adel64;
  logic [31:0] exc_badvaddr, exc_badvaddr64;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  mem_stage_ldq dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_pc(in_pc), .in_ld(in_ld), .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_ex_result(in_ex_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stallreq(stallreq), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
`ifdef MEM_ALIGN_EXC_EN
    .exc_adel(exc_adel), .exc_badvaddr(exc_badvaddr),
`endif
    .dbg_state(dbg_state), .dbg_discard(dbg_discard)
  );

  mem_stage_ldq #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .stall(stall64), .flush(flush64),
    .in_pc(32'h0000_0400), .in_ld(ld64), .in_ld_size(size64), .in_ld_uns(uns64),
    .in_rf_we(we64), .in_rf_waddr(5'd1), .in_ex_result(ex64),
    .dmem_rvalid(rvalid64), .dmem_rdata(rdata64),
    .stallreq(stallreq64), .wb_pc(pc64_o), .wb_rf_we(we64_o), .wb_rf_waddr(waddr64_o),
    .wb_rf_wdata(wdata64_o), .fwd_valid(fwd_valid64), .fwd_we(fwd_we64),
    .fwd_waddr(fwd_waddr64), .fwd_wdata(fwd_wdata64),
`ifdef MEM_ALIGN_EXC_EN
    .exc_adel(exc_adel64), .exc_badvaddr(exc_badvaddr64),
`endif
    .dbg_state(state64), .dbg_discard(discard64)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_wb(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s got=%h exp=<empty queue>", tag, wb_rf_wdata);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {32'd0, wb_rf_wdata}, e);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic [1:0] size, input logic uns,
                          input logic we, input logic [4:0] waddr,
                          input logic [31:0] ex, input logic [31:0] pc);
    in_ld = ld; in_ld_size = size; in_ld_uns = uns; in_rf_we = we;
    in_rf_waddr = waddr; in_ex_result = ex; in_pc = pc;
  endtask

  task automatic drive_nop();
    drive_op(1'b0, LD_B, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic drive_mem(input logic v, input logic [31:0] d);
    dmem_rvalid = v; dmem_rdata = d;
  endtask

  task automatic run64(input string tag, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] rdata,
                       input logic [63:0] exp);
    ld64 = 1'b1; size64 = size; uns64 = uns; we64 = 1'b1; ex64 = addr;
    tick();
    ld64 = 1'b0; we64 = 1'b0; ex64 = '0;
    rvalid64 = 1'b1; rdata64 = rdata;
    @(negedge clk);
    check_eq(tag, wdata64_o, exp);
    check_eq({tag, "_stallreq"}, {63'd0, stallreq64}, 64'd0);
    tick();
    rvalid64 = 1'b0; rdata64 = '0;
  endtask

  initial begin
    rst = 1'b0; stall = SB_NONE; flush = 1'b0;
    drive_nop(); drive_mem(1'b0, 32'd0);
    stall64 = SB_NONE; flush64 = 1'b0; ld64 = 1'b0; size64 = LD_B; uns64 = 1'b0;
    we64 = 1'b0; ex64 = '0; rvalid64 = 1'b0; rdata64 = '0;
    tick(); tick();
    @(negedge clk);
    check_eq("rst_wb_pc", {32'd0, wb_pc}, 64'd0);
    check_eq("rst_wb_we", {63'd0, wb_rf_we}, 64'd0);
    check_eq("rst_wb_wdata", {32'd0, wb_rf_wdata}, 64'd0);
    check_eq("rst_stallreq", {63'd0, stallreq}, 64'd0);
    check_eq("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check_eq("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check_eq("rst_discard", {63'd0, dbg_discard}, 64'd0);
    check_eq("rst_wb64_wdata", wdata64_o, 64'd0);
    rst = 1'b1;
    tick();

    // zero-wait word load
    drive_op(1'b1, LD_W, 1'b0, 1'b1, 5'd5, 32'h0000_1000, 32'h0000_0100);
    tick();
    drive_nop(); drive_mem(1'b1, 32'h8000_00FF);
    exp_q.push_back(64'h8000_00FF);
    @(negedge clk);
    check_eq("t1_stallreq", {63'd0, stallreq}, 64'd0);
    check_wb("t1_wdata");
    check_eq("t1_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    check_eq("t1_waddr", {59'd0, wb_rf_waddr}, 64'd5);
    check_eq("t1_pc", {32'd0, wb_pc}, 64'h100);
    tick();
    drive_mem(1'b0, 32'd0);

    // byte load with 3 cycles of latency, signed then unsigned
    for (int v = 0; v < 2; v++) begin
      drive_op(1'b1, LD_B, (v == 1), 1'b1, 5'd7, 32'h0000_1003, 32'h0000_0104);
      tick();
      drive_nop(); stall = SB_MEMREQ;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check_eq("t2_stallreq_wait", {63'd0, stallreq}, 64'd1);
        check_eq("t2_fwd_valid_wait", {63'd0, fwd_valid}, 64'd0);
        tick();
      end
      stall = SB_NONE; drive_mem(1'b1, 32'h80FF_FFFF);
      exp_q.push_back((v == 1) ? 64'h0000_0080 : 64'hFFFF_FF80);
      @(negedge clk);
      check_eq("t2_stallreq_done", {63'd0, stallreq}, 64'd0);
      check_wb("t2_wdata");
      check_eq("t2_fwd_valid_done", {63'd0, fwd_valid}, 64'd1);
      tick();
      drive_mem(1'b0, 32'd0);
    end

    // data returns while WB is stopped for two cycles
    drive_op(1'b1, LD_W, 1'b0, 1'b1, 5'd9, 32'h0000_2004, 32'h0000_0108);
    tick();
    drive_nop(); drive_mem(1'b1, 32'h1357_2468); stall = SB_MEMREQ;
    exp_q.push_back(64'h1357_2468);
    @(negedge clk);
    check_wb("t3_wdata_rvalid");
    tick();
    drive_mem(1'b0, 32'hFFFF_FFFF);
    exp_q.push_back(64'h1357_2468);
    @(negedge clk);
    check_eq("t3_state_hold1", {62'd0, dbg_state}, {62'd0, ST_HOLD});
    check_wb("t3_wdata_hold1");
    check_eq("t3_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    tick();
    stall = SB_NONE;
    exp_q.push_back(64'h1357_2468);
    @(negedge clk);
    check_eq("t3_state_hold2", {62'd0, dbg_state}, {62'd0, ST_HOLD});
    check_wb("t3_wdata_hold2");
    tick();
    drive_mem(1'b0, 32'd0);
    @(negedge clk);
    check_eq("t3_state_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check_eq("t3_we_after", {63'd0, wb_rf_we}, 64'd0);

    // flush during WAIT, stale response must be dropped
    drive_op(1'b1, LD_W, 1'b0, 1'b1, 5'd3, 32'h0000_3000, 32'h0000_010C);
    tick();
    drive_nop(); stall = SB_MEMREQ;
    @(negedge clk);
    check_eq("t4_stallreq_a", {63'd0, stallreq}, 64'd1);
    tick();
    flush = 1'b1;
    drive_op(1'b1, LD_W, 1'b0, 1'b1, 5'd4, 32'h0000_3008, 32'h0000_0110);
    @(negedge clk);
    check_eq("t4_state_wait", {62'd0, dbg_state}, {62'd0, ST_WAIT});
    tick();
    flush = 1'b0; stall = SB_NONE;
    @(negedge clk);
    check_eq("t4_discard_set", {63'd0, dbg_discard}, 64'd1);
    check_eq("t4_state_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check_eq("t4_we_flushed", {63'd0, wb_rf_we}, 64'd0);
    tick();
    drive_nop(); drive_mem(1'b1, 32'hDEAD_BEEF); stall = SB_MEMREQ;
    @(negedge clk);
    check_eq("t4_stallreq_stale", {63'd0, stallreq}, 64'd1);
    check_eq("t4_fwd_valid_stale", {63'd0, fwd_valid}, 64'd0);
    tick();
    drive_mem(1'b0, 32'd0);
    @(negedge clk);
    check_eq("t4_discard_clr", {63'd0, dbg_discard}, 64'd0);
    check_eq("t4_stallreq_b", {63'd0, stallreq}, 64'd1);
    tick();
    drive_mem(1'b1, 32'h1234_5678); stall = SB_NONE;
    exp_q.push_back(64'h1234_5678);
    @(negedge clk);
    check_wb("t4_wdata");
    check_eq("t4_waddr", {59'd0, wb_rf_waddr}, 64'd4);
    check_eq("t4_stallreq_done", {63'd0, stallreq}, 64'd0);
    tick();
    drive_mem(1'b0, 32'd0);

    // reset while a load waits
    drive_op(1'b1, LD_H, 1'b0, 1'b1, 5'd6, 32'h0000_4000, 32'h0000_0114);
    tick();
    drive_nop(); stall = SB_MEMREQ;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_state_wait", {62'd0, dbg_state}, {62'd0, ST_WAIT});
    tick();
    rst = 1'b1; stall = SB_NONE;
    @(negedge clk);
    check_eq("t5_wb_pc", {32'd0, wb_pc}, 64'd0);
    check_eq("t5_wb_we", {63'd0, wb_rf_we}, 64'd0);
    check_eq("t5_wdata", {32'd0, wb_rf_wdata}, 64'd0);
    check_eq("t5_stallreq", {63'd0, stallreq}, 64'd0);
    check_eq("t5_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check_eq("t5_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check_eq("t5_discard", {63'd0, dbg_discard}, 64'd1);
    drive_mem(1'b1, 32'hAAAA_5555);
    tick();
    drive_mem(1'b0, 32'd0);
    @(negedge clk);
    check_eq("t5_discard_clr", {63'd0, dbg_discard}, 64'd0);

    // non-load result forwarding, then a bubble
    drive_op(1'b0, LD_B, 1'b0, 1'b1, 5'd10, 32'hCAFE_F00D, 32'h0000_0118);
    tick();
    drive_op(1'b0, LD_B, 1'b0, 1'b1, 5'd11, 32'h0000_0055, 32'h0000_011C);
    exp_q.push_back(64'hCAFE_F00D);
    @(negedge clk);
    check_wb("t6_wdata");
    check_eq("t6_fwd_wdata", {32'd0, fwd_wdata}, 64'hCAFE_F00D);
    check_eq("t6_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    check_eq("t6_fwd_we", {63'd0, fwd_we}, 64'd1);
    check_eq("t6_fwd_waddr", {59'd0, fwd_waddr}, 64'd10);
    tick();
    stall = SB_BUBBLE;
    drive_op(1'b0, LD_B, 1'b0, 1'b1, 5'd12, 32'h0000_0066, 32'h0000_0120);
    @(negedge clk);
    check_eq("t6_waddr_pre_bubble", {59'd0, wb_rf_waddr}, 64'd11);
    tick();
    stall = SB_NONE; drive_nop();
    @(negedge clk);
    check_eq("t6_bubble_pc", {32'd0, wb_pc}, 64'd0);
    check_eq("t6_bubble_we", {63'd0, wb_rf_we}, 64'd0);
    tick();

    // signed half load
    drive_op(1'b1, LD_H, 1'b0, 1'b1, 5'd13, 32'h0000_1002, 32'h0000_0124);
    tick();
    drive_nop(); drive_mem(1'b1, 32'h8001_0000);
    exp_q.push_back(64'hFFFF_8001);
    @(negedge clk);
    check_wb("t7_half_signed");
    tick();
    drive_mem(1'b0, 32'd0);
`ifndef MEM_ALIGN_EXC_EN
    // misaligned addresses are force-aligned
    drive_op(1'b1, LD_H, 1'b0, 1'b1, 5'd14, 32'h0000_1003, 32'h0000_0128);
    tick();
    drive_nop(); drive_mem(1'b1, 32'h8001_0000);
    exp_q.push_back(64'hFFFF_8001);
    @(negedge clk);
    check_wb("t7_half_forced");
    tick();
    drive_op(1'b1, LD_W, 1'b0, 1'b1, 5'd15, 32'h0000_1001, 32'h0000_012C);
    drive_mem(1'b0, 32'd0);
    tick();
    drive_nop(); drive_mem(1'b1, 32'h1122_3344);
    exp_q.push_back(64'h1122_3344);
    @(negedge clk);
    check_wb("t7_word_forced");
    tick();
    drive_mem(1'b0, 32'd0);
`endif

    // 64-bit datapath extraction
    run64("t8_half_uns", LD_H, 1'b1, 64'h6, 64'hABCD_0000_0000_0000, 64'h0000_0000_0000_ABCD);
    run64("t8_word_sgn", LD_W, 1'b0, 64'h4, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    run64("t8_word_uns", LD_W, 1'b1, 64'h4, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    run64("t8_dword", LD_D, 1'b0, 64'h0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    run64("t8_byte_sgn", LD_B, 1'b0, 64'h1, 64'h0000_0000_0000_FF00, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef MEM_ALIGN_EXC_EN
    ld64 = 1'b1; size64 = LD_H; uns64 = 1'b1; we64 = 1'b1; ex64 = 64'h5;
    tick();
    ld64 = 1'b0; we64 = 1'b0; ex64 = '0;
    @(negedge clk);
    check_eq("t9_exc_adel", {63'd0, exc_adel64}, 64'd1);
    check_eq("t9_badvaddr", {32'd0, exc_badvaddr64}, 64'd5);
    check_eq("t9_wb_we", {63'd0, we64_o}, 64'd0);
    check_eq("t9_fwd_we", {63'd0, fwd_we64}, 64'd0);
    check_eq("t9_stallreq", {63'd0, stallreq64}, 64'd0);
    tick();
    @(negedge clk);
    check_eq("t9_state", {62'd0, state64}, {62'd0, ST_IDLE});
    check_eq("t9_exc_clr", {63'd0, exc_adel64}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
